// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared constants and helpers for the LED sequence generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

  localparam int MODE_PINGPONG = 0;
  localparam int MODE_ALL      = 1;

  function automatic int unsigned period_of(input int unsigned step,
                                            input int unsigned base,
                                            input int unsigned step_inc);
    return base + step * step_inc;
  endfunction

  // The longest period minus one must fit in the period counter.
  function automatic bit params_ok(input int unsigned ch,
                                   input int unsigned cnt_w,
                                   input int unsigned steps,
                                   input int unsigned base,
                                   input int unsigned step_inc,
                                   input int unsigned on_time);
    bit              ok;
    longint unsigned max_p;
    ok = (ch >= 1) && (steps >= 1) && (on_time >= 1) && (on_time < base) &&
         (cnt_w >= 1) && (cnt_w <= 32);
    if (ok) begin
      max_p = 64'(base) + 64'(steps - 1) * 64'(step_inc);
      ok    = (max_p - 64'd1) < (64'd1 << cnt_w);
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_period_timer.sv
// ============================================================================
// Module      : led_period_timer
// Description : Period counter with end-of-period detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_period_timer #(
  parameter int CNT_W = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             pause,
  input  logic [CNT_W-1:0] period_len,
  output logic [CNT_W-1:0] cnt,
  output logic             period_last
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == period_len - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_cnt <= '0;
    end else if (!pause) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign cnt         = r_cnt;
  assign period_last = w_last & ~pause;

endmodule

`default_nettype wire

// File: rtl/led_seq_gen.sv
// ============================================================================
// Module      : led_seq_gen
// Description : Multi-channel LED chaser stepping through a period table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_gen
  import led_seq_pkg::*;
#(
  parameter int          CH             = 4,
  parameter int          CNT_W          = 29,
  parameter int          STEPS          = 9,
  parameter int unsigned BASE           = 100_000_000,
  parameter int unsigned STEP_INC       = 50_000_000,
  parameter int unsigned ON_TIME        = 50_000_000,
  parameter bit          LED_ACTIVE_LOW = 1'b1,
  localparam int         SW             = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          pause,
  input  logic [1:0]    mode,
  output logic [CH-1:0] led,
  output logic [SW-1:0] step,
  output logic          period_end
);

  localparam int            CW          = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [SW-1:0] c_last_step = SW'(STEPS - 1);
  localparam logic [CW-1:0] c_last_ch   = CW'(CH - 1);
  localparam logic [CH-1:0] c_led_off   = {CH{LED_ACTIVE_LOW}};

  if (!params_ok(CH, CNT_W, STEPS, BASE, STEP_INC, ON_TIME)) begin : g_bad_params
    $error("led_seq_gen: invalid parameter set");
  end

  logic [SW-1:0]    r_step;
  logic             r_dir_up;
  logic [CW-1:0]    r_ch_idx;
  logic [1:0]       r_mode_q;
  logic [CH-1:0]    r_led;
  logic             r_period_end;

  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_cnt;
  logic             w_last;
  logic             w_on;
  logic [CH-1:0]    w_chase;
  logic [CH-1:0]    w_active;
  logic [SW-1:0]    w_step_next;
  logic             w_dir_next;

  assign w_period = CNT_W'(period_of(32'(r_step), BASE, STEP_INC));

  led_period_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (~en),
    .pause       (pause),
    .period_len  (w_period),
    .cnt         (w_cnt),
    .period_last (w_last)
  );

  // Ping-pong turns around at either end without repeating the end value.
  always_comb begin
    w_step_next = r_step;
    w_dir_next  = r_dir_up;
    if (STEPS > 1) begin
      if (!r_mode_q[MODE_PINGPONG]) begin
        w_step_next = (r_step == c_last_step) ? '0 : r_step + SW'(1);
      end else if (r_dir_up) begin
        if (r_step == c_last_step) begin
          w_step_next = r_step - SW'(1);
          w_dir_next  = 1'b0;
        end else begin
          w_step_next = r_step + SW'(1);
        end
      end else begin
        if (r_step == '0) begin
          w_step_next = SW'(1);
          w_dir_next  = 1'b1;
        end else begin
          w_step_next = r_step - SW'(1);
        end
      end
    end
  end

  assign w_on = (w_cnt < CNT_W'(ON_TIME));

  always_comb begin
    w_chase = '0;
    for (int i = 0; i < CH; i++) begin
      w_chase[i] = (r_ch_idx == CW'(i));
    end
    if (!w_on) begin
      w_active = '0;
    end else if (r_mode_q[MODE_ALL]) begin
      w_active = '1;
    end else begin
      w_active = w_chase;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_step       <= '0;
      r_dir_up     <= 1'b1;
      r_ch_idx     <= '0;
      r_led        <= c_led_off;
      r_period_end <= 1'b0;
      r_mode_q     <= mode;
    end else if (pause) begin
      r_period_end <= 1'b0;
    end else begin
      r_led        <= LED_ACTIVE_LOW ? ~w_active : w_active;
      r_period_end <= w_last;
      if (w_last) begin
        r_step   <= w_step_next;
        r_dir_up <= w_dir_next;
        r_ch_idx <= (r_ch_idx == c_last_ch) ? '0 : r_ch_idx + CW'(1);
        r_mode_q <= mode;
      end
    end
  end

  assign led        = r_led;
  assign step       = r_step;
  assign period_end = r_period_end;

endmodule

`default_nettype wire

// File: tb/tb_led_seq_gen.sv
// ============================================================================
// Module      : tb_led_seq_gen
// Description : Self-checking bench for led_seq_gen with a period-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_seq_gen;

  localparam int CH       = 4;
  localparam int CNT_W    = 6;
  localparam int STEPS    = 3;
  localparam int BASE     = 10;
  localparam int STEP_INC = 5;
  localparam int ON_TIME  = 4;
  localparam int SW       = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b1;
  logic          pause = 1'b0;
  logic [1:0]    mode  = 2'b00;
  logic [CH-1:0] led;
  logic [SW-1:0] step;
  logic          period_end;

  led_seq_gen #(
    .CH             (CH),
    .CNT_W          (CNT_W),
    .STEPS          (STEPS),
    .BASE           (BASE),
    .STEP_INC       (STEP_INC),
    .ON_TIME        (ON_TIME),
    .LED_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pause      (pause),
    .mode       (mode),
    .led        (led),
    .step       (step),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  bit cmp_on = 1'b0;

  // Model tracks which period we are in and the position inside it.
  int            m_k    = 0;
  int            m_t    = 0;
  logic [1:0]    m_mode = 2'b00;
  logic [CH-1:0] m_led  = '0;
  logic          m_pe   = 1'b0;

  function automatic int exp_step(input int k, input logic pp);
    int r;
    if (STEPS == 1) return 0;
    if (!pp) return k % STEPS;
    r = k % (2 * (STEPS - 1));
    return (r < STEPS) ? r : 2 * (STEPS - 1) - r;
  endfunction

  function automatic int plen(input int s);
    return BASE + s * STEP_INC;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n || !en) begin
      m_k = 0; m_t = 0; m_led = '0; m_pe = 1'b0; m_mode = mode;
    end else if (pause) begin
      m_pe = 1'b0;
    end else begin
      if (m_t < ON_TIME) m_led = m_mode[1] ? {CH{1'b1}} : CH'(1 << (m_k % CH));
      else               m_led = '0;
      if (m_t == plen(exp_step(m_k, m_mode[0])) - 1) begin
        m_t = 0; m_k++; m_mode = mode; m_pe = 1'b1;
      end else begin
        m_t++; m_pe = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_led", 32'(led), 32'(m_led));
      chk("model_step", 32'(step), 32'(exp_step(m_k, m_mode[0])));
      chk("model_pe", 32'(period_end), 32'(m_pe));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start(input logic [1:0] m);
    rst_n = 1'b0; en = 1'b1; pause = 1'b0; mode = m;
    tick();
    cmp_on = 1'b1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_pe", 32'(period_end), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // ramp-up chase
    start(2'b00);
    chk("pre_run_led", 32'(led), 32'h0);
    chk("pre_run_step", 32'(step), 32'h0);
    run_until(1);  chk("c1_led", 32'(led), 32'h1); chk("c1_pe", 32'(period_end), 32'h0);
    run_until(4);  chk("c4_led", 32'(led), 32'h1);
    run_until(5);  chk("c5_led", 32'(led), 32'h0);
    run_until(9);  chk("c9_pe", 32'(period_end), 32'h0);
    run_until(10); chk("c10_pe", 32'(period_end), 32'h1); chk("c10_step", 32'(step), 32'h1);
    run_until(11); chk("c11_led", 32'(led), 32'h2); chk("c11_pe", 32'(period_end), 32'h0);
    run_until(25); chk("c25_pe", 32'(period_end), 32'h1); chk("c25_step", 32'(step), 32'h2);
    run_until(27); chk("c27_led", 32'(led), 32'h4);
    run_until(45); chk("c45_pe", 32'(period_end), 32'h1); chk("c45_step", 32'(step), 32'h0);
    run_until(55); chk("c55_pe", 32'(period_end), 32'h1); chk("c55_step", 32'(step), 32'h1);

    // ping-pong: lengths 10,15,20,15,10,15
    start(2'b01);
    run_until(10); chk("pp10_step", 32'(step), 32'h1);
    run_until(25); chk("pp25_step", 32'(step), 32'h2);
    run_until(45); chk("pp45_step", 32'(step), 32'h1); chk("pp45_pe", 32'(period_end), 32'h1);
    run_until(59); chk("pp59_pe", 32'(period_end), 32'h0);
    run_until(60); chk("pp60_step", 32'(step), 32'h0); chk("pp60_pe", 32'(period_end), 32'h1);
    run_until(70); chk("pp70_step", 32'(step), 32'h1); chk("pp70_pe", 32'(period_end), 32'h1);
    run_until(85); chk("pp85_pe", 32'(period_end), 32'h1); chk("pp85_step", 32'(step), 32'h2);

    // all channels
    start(2'b10);
    run_until(2);  chk("all2_led", 32'(led), 32'hF);
    run_until(6);  chk("all6_led", 32'(led), 32'h0);
    run_until(10); chk("all10_step", 32'(step), 32'h1);
    run_until(12); chk("all12_led", 32'(led), 32'hF);

    // mode change takes effect at the next period boundary
    start(2'b00);
    run_until(5);  mode = 2'b10;
    run_until(6);  chk("mc6_led", 32'(led), 32'h0);
    run_until(10); chk("mc10_led", 32'(led), 32'h0);
    run_until(11); chk("mc11_led", 32'(led), 32'hF);

    // pause across cycles 3..7
    start(2'b00);
    run_until(3);  pause = 1'b1;
    run_until(6);  chk("pz6_led", 32'(led), 32'h1); chk("pz6_pe", 32'(period_end), 32'h0);
    run_until(8);  pause = 1'b0;
    run_until(10); chk("pz10_pe", 32'(period_end), 32'h0);
    run_until(15); chk("pz15_pe", 32'(period_end), 32'h1); chk("pz15_step", 32'(step), 32'h1);

    // synchronous clear by en
    start(2'b00);
    run_until(12); chk("en12_step", 32'(step), 32'h1);
    en = 1'b0;
    run_until(13); chk("en13_led", 32'(led), 32'h0); chk("en13_step", 32'(step), 32'h0);
    en = 1'b1;
    run_until(23); chk("en23_pe", 32'(period_end), 32'h1);

    // reset mid-period
    start(2'b00);
    run_until(30); rst_n = 1'b0;
    run_until(31); rst_n = 1'b1;
    chk("rs31_led", 32'(led), 32'h0); chk("rs31_step", 32'(step), 32'h0);
    run_until(33); chk("rs33_led", 32'(led), 32'h1);
    run_until(40); chk("rs40_pe", 32'(period_end), 32'h0);
    run_until(41); chk("rs41_pe", 32'(period_end), 32'h1); chk("rs41_step", 32'(step), 32'h1);
    run_until(45);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_seq_gen.md
Name: led_seq_gen

Overview:
- Parametrised successor to the single-LED variable-period blinker.
- A period counter steps through a programmable arithmetic table of periods.
- Drives CH LED channels in chase or all-together mode, with ramp-up or ping-pong sweeps, run enable and pause.
- Sits between the board clock and the LED pins; no bus interface.

Parameters:
CH, 4, number of LED channels (>=1)
CNT_W, 29, period counter width; must hold BASE+(STEPS-1)*STEP_INC-1
STEPS, 9, number of period-table entries (>=1)
BASE, 100_000_000, period of step 0 in clocks
STEP_INC, 50_000_000, period increment per step in clocks
ON_TIME, 50_000_000, active-LED clocks per period; must be <BASE and >=1 (elaboration check)
LED_ACTIVE_LOW, 1, 1: active LED drives 0, inactive drives 1

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
en  in  1  run enable; 0 = synchronous clear to reset state
pause  in  1  freeze all state while 1
mode  in  2  [0]: 0 = ramp-up wrap, 1 = ping-pong; [1]: 0 = chase, 1 = all channels
led  out  CH  LED drive
step  out  SW  current table index, SW = max(1, clog2(STEPS))
period_end  out  1  one-cycle pulse at each period boundary

Behaviour:
- Reset (rst_n=0 at clk edge):
  - cnt0=0, step=0, dir=up, ch_idx=0, period_end=0.
  - led = all inactive (all 1 when LED_ACTIVE_LOW, else all 0).
  - mode_q captures mode.
- Period: P(s) = BASE + s*STEP_INC, computed in CNT_W bits. cnt0 counts 0..P(step)-1, then wraps to 0.
- Cycle 0 is the first edge with rst_n=1, en=1, pause=0. In cycle 0, cnt0=0.
- LED timing:
  - on_c = (cnt0 < ON_TIME), registered into led, so led lags cnt0 by 1 clock.
  - Chase (mode_q[1]=0): only led[ch_idx] is driven active when on_c=1; all other channels are inactive.
  - All (mode_q[1]=1): every channel is driven active when on_c=1.
- Period boundary: the clock where cnt0==P(step)-1. On this clock:
  - cnt0 <= 0.
  - ch_idx <= (ch_idx==CH-1) ? 0 : ch_idx+1.
  - step advances per mode_q[0].
  - mode_q <= mode; mode is sampled only here, so a mid-period change has no effect until the next period.
  - period_end is registered and is high during the cycle in which cnt0==0 of the new period.
- Ramp-up: step 0,1,...,STEPS-1, then 0.
- Ping-pong:
  - step 0,1,...,STEPS-1,STEPS-2,...,1,0,1,...
  - dir flips at each end; end values are never repeated.
- STEPS==1: step stays 0 in both sweep modes.
- pause=1: cnt0, step, dir, ch_idx, mode_q and led hold; period_end is forced 0.
- en=0: synchronous clear to the reset state except mode_q, which captures mode. en=0 dominates pause.
- rst_n=0 mid-period: full reset on that edge. The next period starts from step 0 with length BASE.
- The step index is checked against STEPS-1, so out-of-range indices are unreachable (no default-period hole).

Decomposition:
- Package led_seq_pkg holds:
  - mode bit position constants MODE_PINGPONG=0 and MODE_ALL=1;
  - the function period_of(step) returning BASE+step*STEP_INC;
  - the elaboration checks for ON_TIME, STEPS, CH and CNT_W.
- Sub-module led_period_timer holds cnt0 and the boundary-end detection (inputs: period length, pause, clear; output: end).
- The top level holds step/dir/ch_idx sequencing, mode_q and LED decode.

Test Plan:
All scenarios use CH=4, BASE=10, STEP_INC=5, STEPS=3, ON_TIME=4, LED_ACTIVE_LOW=0, CNT_W=6.
- Reset: hold rst_n=0 for 3 clocks with en=1 -> led=4'b0000, step=0, period_end=0; check both before and after the first clean edge.
- mode=00, en=1 from cycle 0:
  - period_end high in cycles 10, 25, 45, 55; step reads 0,1,2,0.
  - led=4'b0001 in cycles 1-4; led=4'b0010 in cycles 11-14; led=4'b0100 in cycles 26-29; led=0 otherwise.
- mode=01 for 6 periods -> step sequence 0,1,2,1,0,1; period lengths 10,15,20,15,10,15.
- mode=10 -> led=4'b1111 in cycles 1-4 and 11-14; step still ramps.
- Change mode 00->10 at cycle 5 -> led stays chase (4'b0000) for the rest of period 0; led=4'b1111 from cycle 11.
- Robustness:
  - pause=1 for cycles 3-7 -> led and cnt0 frozen; period_end delayed to cycle 15.
  - en=0 at cycle 12 -> led=0, step=0 next cycle.
  - rst_n=0 at cycle 30 -> the next period is 10 clocks with led=4'b0001.
